// File: rtl/mm_port_arbiter.sv
// Two-requester round-robin arbiter for the line-wide main memory port.
// One transaction in flight; read data and acks are routed back to the owner.
module mm_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 256,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] r0_a,
  input  logic [DW-1:0] r0_wd,
  input  logic          r0_read,
  input  logic          r0_write,
  output logic [DW-1:0] r0_rd,
  output logic          r0_rd_valid,
  output logic          r0_ack,
  output logic          r0_err,
  input  logic [AW-1:0] r1_a,
  input  logic [DW-1:0] r1_wd,
  input  logic          r1_read,
  input  logic          r1_write,
  output logic [DW-1:0] r1_rd,
  output logic          r1_rd_valid,
  output logic          r1_ack,
  output logic          r1_err,
  output logic [AW-1:0] mm_a,
  output logic [DW-1:0] mm_wd,
  output logic          mm_read,
  output logic          mm_write,
  input  logic [DW-1:0] mm_rd,
  input  logic          mm_valid,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               state, state_n;
  logic                 rr;      // requester favoured when both are pending
  logic                 op_wr;
  logic [7:0]           timer;
  logic [1:0]           pend;
  logic                 gnt;
  logic                 sel_wr;
  logic [AW-1:0]        sel_a;
  logic [DW-1:0]        sel_wd;
  logic [1:0]           ack_q, err_q, rdv_q;
  logic [1:0][DW-1:0]   rd_q;

  assign r0_ack      = ack_q[0];
  assign r1_ack      = ack_q[1];
  assign r0_err      = err_q[0];
  assign r1_err      = err_q[1];
  assign r0_rd_valid = rdv_q[0];
  assign r1_rd_valid = rdv_q[1];
  assign r0_rd       = rd_q[0];
  assign r1_rd       = rd_q[1];

  // A requester still holding its request during its own ack cycle is not re-granted.
  always_comb begin
    pend    = {(r1_read | r1_write) & ~ack_q[1], (r0_read | r0_write) & ~ack_q[0]};
    gnt     = (pend == 2'b11) ? rr : pend[1];
    sel_wr  = gnt ? r1_write : r0_write;
    sel_a   = gnt ? r1_a     : r0_a;
    sel_wd  = gnt ? r1_wd    : r0_wd;
    state_n = state;
    case (state)
      IDLE:    if (|pend) state_n = ISSUE;
      ISSUE:   state_n = op_wr ? IDLE : WAIT_RD;
      WAIT_RD: if (mm_valid || timer == TMO_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr       <= 1'b0;
      op_wr    <= 1'b0;
      timer    <= '0;
      owner    <= 1'b0;
      busy     <= 1'b0;
      mm_a     <= '0;
      mm_wd    <= '0;
      mm_read  <= 1'b0;
      mm_write <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
      rdv_q    <= '0;
      rd_q     <= '0;
    end else begin
      state    <= state_n;
      busy     <= (state_n != IDLE);
      mm_read  <= 1'b0;
      mm_write <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
      rdv_q    <= '0;
      rd_q     <= '0;
      case (state)
        IDLE: if (|pend) begin
          owner    <= gnt;
          op_wr    <= sel_wr;
          mm_a     <= sel_a;
          mm_wd    <= sel_wd;
          mm_write <= sel_wr;
          mm_read  <= ~sel_wr;
        end
        ISSUE: begin
          timer <= '0;
          if (op_wr) begin
            ack_q[owner] <= 1'b1;
            rr           <= ~owner;
          end
        end
        WAIT_RD: begin
          if (timer != 8'hFF) timer <= timer + 8'd1;
          if (mm_valid) begin
            rd_q[owner]  <= mm_rd;
            rdv_q[owner] <= 1'b1;
            ack_q[owner] <= 1'b1;
            rr           <= ~owner;
          end else if (timer == TMO_LAST) begin
            ack_q[owner] <= 1'b1;
            err_q[owner] <= 1'b1;
            rr           <= ~owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Bench for mm_port_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level round-robin model with a behavioural memory.
module tb_mm_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 256;
  localparam int TMO = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] r0_a = '0, r1_a = '0, mm_a;
  logic [DW-1:0] r0_wd = '0, r1_wd = '0, r0_rd, r1_rd, mm_wd, mm_rd = '0;
  logic          r0_read = 0, r0_write = 0, r1_read = 0, r1_write = 0;
  logic          r0_rd_valid, r0_ack, r0_err, r1_rd_valid, r1_ack, r1_err;
  logic          mm_read, mm_write, mm_valid = 0, busy, owner;

  always #5 clk = ~clk;

  mm_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .r0_a(r0_a), .r0_wd(r0_wd), .r0_read(r0_read), .r0_write(r0_write),
    .r0_rd(r0_rd), .r0_rd_valid(r0_rd_valid), .r0_ack(r0_ack), .r0_err(r0_err),
    .r1_a(r1_a), .r1_wd(r1_wd), .r1_read(r1_read), .r1_write(r1_write),
    .r1_rd(r1_rd), .r1_rd_valid(r1_rd_valid), .r1_ack(r1_ack), .r1_err(r1_err),
    .mm_a(mm_a), .mm_wd(mm_wd), .mm_read(mm_read), .mm_write(mm_write),
    .mm_rd(mm_rd), .mm_valid(mm_valid), .busy(busy), .owner(owner)
  );

  int n_chk = 0, n_err = 0, cyc = 0;

  // requester agents: request held until its ack is seen
  bit            req_on[2], req_rdf[2], req_wrf[2], just_acked[2];
  logic [AW-1:0] req_a[2];
  logic [DW-1:0] req_wd[2];

  // transaction-level model
  bit            m_busy, m_wr, m_owner, rr_m, prev_idle;
  logic [1:0]    prev_pend;
  int            m_start, m_lat, m_done;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_wd;
  int            owner_log[$], strobe_log[$], done_log[$];
  int            forced_lat = -1;
  bit            rand_mode = 0, auto_wr = 0, force_stray = 0;
  int            n_rd_strobe = 0, n_wr_strobe = 0;
  logic [AW-1:0] strobe_a;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_ports();
    r0_read  = req_on[0] && req_rdf[0];
    r0_write = req_on[0] && req_wrf[0];
    r0_a     = req_a[0];
    r0_wd    = req_wd[0];
    r1_read  = req_on[1] && req_rdf[1];
    r1_write = req_on[1] && req_wrf[1];
    r1_a     = req_a[1];
    r1_wd    = req_wd[1];
  endtask

  task automatic start_req(input int i, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_on[i] = 1; req_rdf[i] = rd; req_wrf[i] = wr; req_a[i] = a; req_wd[i] = wd;
    drive_ports();
    prev_pend = {req_on[1], req_on[0]};
  endtask

  // One clock: check this cycle's outputs against the model, then drive the next inputs.
  task automatic cycle();
    logic [1:0] ack_e, err_e, rdv_e;
    bit         str_e;
    int         g, k;
    @(posedge clk); #1;
    cyc++;
    ack_e = '0; err_e = '0; rdv_e = '0; str_e = 0;
    just_acked[0] = 0; just_acked[1] = 0;
    if (mm_read)  n_rd_strobe++;
    if (mm_write) n_wr_strobe++;
    if (prev_idle && prev_pend != 2'b00) begin
      g       = (prev_pend == 2'b11) ? int'(rr_m) : int'(prev_pend[1]);
      str_e   = 1;
      m_busy  = 1;
      m_owner = g[0];
      m_wr    = req_wrf[g];
      m_start = cyc;
      last_a  = req_a[g];
      last_wd = req_wd[g];
      strobe_a = mm_a;
      if (forced_lat >= 0) m_lat = forced_lat;
      else m_lat = ($urandom_range(0, 4) == 0) ? TMO + 3 : int'($urandom_range(1, TMO));
      m_done  = m_wr ? cyc + 1 : (m_lat <= TMO ? cyc + m_lat + 1 : cyc + TMO + 1);
      m_rdata = rnd_line();
      owner_log.push_back(g);
      strobe_log.push_back(cyc);
    end else if (m_busy && cyc == m_done) begin
      ack_e[m_owner] = 1;
      if (!m_wr) begin
        if (m_lat <= TMO) rdv_e[m_owner] = 1;
        else              err_e[m_owner] = 1;
      end
      m_busy = 0;
      rr_m   = !m_owner;
      req_on[m_owner]     = 0;
      just_acked[m_owner] = 1;
      done_log.push_back(cyc);
    end
    chk("ctl", {busy, mm_read, mm_write, owner, r1_ack, r1_err, r1_rd_valid, r0_ack, r0_err, r0_rd_valid},
               {m_busy, str_e && !m_wr, str_e && m_wr, m_owner, ack_e[1], err_e[1], rdv_e[1],
                ack_e[0], err_e[0], rdv_e[0]});
    chk("mm_a", mm_a, last_a);
    chk("mm_wd", mm_wd, last_wd);
    if (rdv_e[0]) begin chk("r0_rd", r0_rd, m_rdata); chk("r1_rd_nonowner", r1_rd, '0); end
    if (rdv_e[1]) begin chk("r1_rd", r1_rd, m_rdata); chk("r0_rd_nonowner", r0_rd, '0); end

    for (int i = 0; i < 2; i++)
      if (!req_on[i] && !just_acked[i] && !reset) begin
        if (auto_wr) start_req(i, 0, 1, $urandom, rnd_line());
        else if (rand_mode && $urandom_range(0, 3) == 0) begin
          k = $urandom_range(0, 3);
          start_req(i, k == 0 || k == 2, k != 0, $urandom, rnd_line());
        end
      end
    mm_valid = 0;
    mm_rd    = rnd_line();
    if (m_busy && !m_wr && cyc == m_start + m_lat) begin
      mm_valid = 1;
      mm_rd    = m_rdata;
    end else if (!(m_busy && !m_wr) && (force_stray || (rand_mode && $urandom_range(0, 5) == 0)))
      mm_valid = 1;
    drive_ports();
    prev_pend = {req_on[1], req_on[0]};
    prev_idle = !m_busy;
  endtask

  task automatic apply_reset(input int n);
    reset = 1;
    mm_valid = 0;
    for (int i = 0; i < 2; i++) req_on[i] = 0;
    drive_ports();
    m_busy = 0; rr_m = 0; m_owner = 0; m_wr = 0;
    last_a = '0; last_wd = '0; prev_pend = '0; prev_idle = 1;
    repeat (n) cycle();
    reset = 0;
  endtask

  task automatic run_idle(input int max);
    int k;
    k = 0;
    while ((m_busy || req_on[0] || req_on[1]) && k < max) begin cycle(); k++; end
    if (k >= max) chk("idle_bound", {m_busy, req_on[1], req_on[0]}, '0);
  endtask

  initial begin
    int t0, g0, d0;
    for (int i = 0; i < 2; i++) begin
      req_on[i] = 0; req_rdf[i] = 0; req_wrf[i] = 0; req_a[i] = '0; req_wd[i] = '0;
    end
    apply_reset(2);

    // single R0 write: strobe at N+1, ack at N+2
    start_req(0, 0, 1, 32'h40, {8{32'hA5A5A5A5}});
    t0 = cyc; g0 = strobe_log.size(); d0 = done_log.size();
    run_idle(50);
    if (strobe_log.size() > g0 && done_log.size() > d0) begin
      chk("t1_strobe_lat", strobe_log[g0] - t0, 1);
      chk("t1_ack_lat", done_log[d0] - t0, 2);
      chk("t1_mm_a", strobe_a, 32'h40);
    end else chk("t1_done", done_log.size() - d0, 1);

    // simultaneous reads after reset, memory latency 3
    apply_reset(2);
    forced_lat = 3;
    start_req(0, 1, 0, $urandom, rnd_line());
    start_req(1, 1, 0, $urandom, rnd_line());
    g0 = owner_log.size(); d0 = done_log.size();
    run_idle(100);
    if (owner_log.size() >= g0 + 2 && done_log.size() >= d0 + 2) begin
      chk("t2_first_owner", owner_log[g0], 0);
      chk("t2_second_owner", owner_log[g0+1], 1);
      chk("t2_r0_rd_lat", done_log[d0] - strobe_log[g0], 4);
      chk("t2_r1_rd_lat", done_log[d0+1] - strobe_log[g0+1], 4);
    end else chk("t2_grants", owner_log.size() - g0, 2);

    // continuous writes from both: strict alternation
    apply_reset(2);
    forced_lat = -1;
    auto_wr = 1;
    g0 = owner_log.size();
    for (int k = 0; k < 100 && owner_log.size() - g0 < 6; k++) cycle();
    auto_wr = 0;
    run_idle(50);
    if (owner_log.size() - g0 >= 6)
      for (int k = 0; k < 6; k++) chk("t3_alternate", owner_log[g0+k], k % 2);
    else chk("t3_grants", owner_log.size() - g0, 6);

    // R1 read with no memory response: ack+err at strobe+TIMEOUT+1
    apply_reset(2);
    forced_lat = TMO + 5;
    start_req(1, 1, 0, $urandom, rnd_line());
    g0 = strobe_log.size(); d0 = done_log.size();
    run_idle(100);
    if (strobe_log.size() > g0 && done_log.size() > d0)
      chk("t4_timeout_lat", done_log[d0] - strobe_log[g0], TMO + 1);
    else chk("t4_done", done_log.size() - d0, 1);

    // reset while waiting for read data, then stray mm_valid
    apply_reset(2);
    start_req(0, 1, 0, $urandom, rnd_line());
    for (int k = 0; k < 30 && !(m_busy && cyc >= m_start + 3); k++) cycle();
    apply_reset(1);
    force_stray = 1;
    repeat (2) cycle();
    force_stray = 0;
    repeat (3) cycle();
    forced_lat = 2;
    start_req(1, 1, 0, $urandom, rnd_line());
    start_req(0, 1, 0, $urandom, rnd_line());
    g0 = owner_log.size();
    run_idle(100);
    if (owner_log.size() > g0) chk("t5_first_owner", owner_log[g0], 0);
    else chk("t5_grants", owner_log.size() - g0, 1);

    // stray mm_valid while idle; read+write together is a write
    apply_reset(2);
    force_stray = 1;
    repeat (3) cycle();
    n_rd_strobe = 0; n_wr_strobe = 0;
    start_req(0, 1, 1, 32'h1234_5680, rnd_line());
    run_idle(50);
    repeat (3) cycle();
    force_stray = 0;
    chk("t6_no_read_strobe", n_rd_strobe, 0);
    chk("t6_write_strobe", n_wr_strobe, 1);

    // random traffic with one mid-run reset
    apply_reset(2);
    forced_lat = -1;
    rand_mode = 1;
    repeat (800) cycle();
    apply_reset(2);
    repeat (800) cycle();
    rand_mode = 0;
    run_idle(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
